// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
// Shared definitions for the pulse rate meter:
//   - meter_state_e : measurement FSM states (IDLE, COUNT)
//   - WIDE_ZERO / WIDE_ONE : zero/one constants wide enough for any supported
//     counter width; users slice them down to their own width.
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } meter_state_e;

    // Widest counter supported by the width-derived constants below.
    localparam int MAX_WIDTH = 64;

    localparam logic [MAX_WIDTH-1:0] WIDE_ZERO = 64'd0;
    localparam logic [MAX_WIDTH-1:0] WIDE_ONE  = 64'd1;

endpackage

// File: rtl/window_timer.sv
// -----------------------------------------------------------------------------
// window_timer
// Loadable down-counter that measures one window in clock cycles and flags the
// window's final cycle.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset (counter cleared to 0)
//   load    in  load counter with length (0 treated as 1)
//   clear   in  force counter to 0 (lower priority than load)
//   length  in  window length in clock cycles
//   last    out high during the final cycle of the window (counter == 1)
// -----------------------------------------------------------------------------
module window_timer
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] length,
    output logic             last
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDE_ZERO[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDE_ONE[WIDTH-1:0];

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] rem_next_s;
    logic             last_r;

    // Next remaining-cycles value: load, clear, or count down to zero.
    always_comb begin
        rem_next_s = rem_r;
        if (load) begin
            // A zero length would never reach the final-cycle flag.
            rem_next_s = (length == CNT_ZERO) ? CNT_ONE : length;
        end else if (clear) begin
            rem_next_s = CNT_ZERO;
        end else if (rem_r != CNT_ZERO) begin
            rem_next_s = rem_r - CNT_ONE;
        end else begin
            rem_next_s = rem_r;
        end
    end

    // Counter register; the final-cycle flag is decoded from the next value so
    // it comes straight out of a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_r  <= CNT_ZERO;
            last_r <= 1'b0;
        end else begin
            rem_r  <= rem_next_s;
            last_r <= (rem_next_s == CNT_ONE);
        end
    end

    assign last = last_r;

endmodule

// File: rtl/pulse_rate_meter.sv
// -----------------------------------------------------------------------------
// pulse_rate_meter
// Counts high cycles of pulses_in over back-to-back windows of window_length
// clock cycles and presents each window's count on a valid/ready output.
// A result arriving while the previous one is still unconsumed is dropped and
// flagged on the sticky overrun output.
// Ports:
//   clock         in  sole clock, rising edge
//   reset_n       in  asynchronous active-low reset
//   enable        in  1 = measure continuously, 0 = idle (partial window lost)
//   restart       in  abort and restart current window, clears overrun
//   window_length in  window length in cycles, sampled at each window start
//   pulses_in     in  event input, one event per high cycle
//   out_valid     out out_count holds an unconsumed result
//   out_ready     in  consumer accepts result when high with out_valid
//   out_count     out events in the last completed window
//   overrun       out sticky: a completed result was dropped
// Build option:
//   PULSE_RATE_METER_SATURATE_EN defined -> accumulator saturates at all-ones;
//   otherwise it wraps modulo 2^WORD_WIDTH.
// -----------------------------------------------------------------------------
module pulse_rate_meter
    import pulse_meter_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int WINDOW_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    restart,
    input  logic [WINDOW_WIDTH-1:0] window_length,
    input  logic                    pulses_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   out_count,
    output logic                    overrun
);

    localparam logic [WORD_WIDTH-1:0] ACC_ZERO = WIDE_ZERO[WORD_WIDTH-1:0];
    localparam logic [WORD_WIDTH-1:0] ACC_ONE  = WIDE_ONE[WORD_WIDTH-1:0];
    localparam logic [WORD_WIDTH-1:0] ACC_FULL = ~ACC_ZERO;

    // Accumulator increment, wrapping or saturating depending on the build.
    function automatic logic [WORD_WIDTH-1:0] acc_inc(
        input logic [WORD_WIDTH-1:0] value,
        input logic                  pulse
    );
`ifdef PULSE_RATE_METER_SATURATE_EN
        if (pulse && (value != ACC_FULL)) begin
            return value + ACC_ONE;
        end else begin
            return value;
        end
`else
        if (pulse) begin
            return value + ACC_ONE;
        end else begin
            return value;
        end
`endif
    endfunction

    meter_state_e          state_r;
    meter_state_e          state_next_s;
    logic [WORD_WIDTH-1:0] acc_r;
    logic [WORD_WIDTH-1:0] acc_next_s;
    logic [WORD_WIDTH-1:0] result_s;
    logic                  timer_load_s;
    logic                  timer_clear_s;
    logic                  timer_last_s;
    logic                  complete_s;
    logic                  out_valid_r;
    logic                  out_valid_next_s;
    logic [WORD_WIDTH-1:0] out_count_r;
    logic [WORD_WIDTH-1:0] out_count_next_s;
    logic                  overrun_r;
    logic                  overrun_next_s;

    window_timer #(
        .WIDTH (WINDOW_WIDTH)
    ) u_window_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load_s),
        .clear   (timer_clear_s),
        .length  (window_length),
        .last    (timer_last_s)
    );

    // Count including the current cycle's pulse; on a final cycle this is the
    // window result.
    assign result_s = acc_inc(acc_r, pulses_in);

    // Next-state, timer control and accumulator update.
    always_comb begin
        state_next_s  = state_r;
        timer_load_s  = 1'b0;
        timer_clear_s = 1'b0;
        acc_next_s    = ACC_ZERO;
        complete_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = COUNT;
                    timer_load_s = 1'b1;
                end else begin
                    timer_clear_s = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    // Partial window is thrown away.
                    state_next_s  = IDLE;
                    timer_clear_s = 1'b1;
                end else if (restart) begin
                    // Beats window completion; this cycle's pulse is dropped.
                    timer_load_s = 1'b1;
                end else if (timer_last_s) begin
                    // Next window starts right away, no gap cycle.
                    timer_load_s = 1'b1;
                    complete_s   = 1'b1;
                end else begin
                    acc_next_s = result_s;
                end
            end
            default: begin
                state_next_s  = IDLE;
                timer_clear_s = 1'b1;
            end
        endcase
    end

    // Output handshake and sticky overrun.
    always_comb begin
        out_valid_next_s = out_valid_r;
        out_count_next_s = out_count_r;
        overrun_next_s   = overrun_r;
        if (complete_s && (!out_valid_r || out_ready)) begin
            out_valid_next_s = 1'b1;
            out_count_next_s = result_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
        if (restart) begin
            overrun_next_s = 1'b0;
        end else if (complete_s && out_valid_r && !out_ready) begin
            overrun_next_s = 1'b1;
        end else begin
            overrun_next_s = overrun_r;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            acc_r       <= ACC_ZERO;
            out_valid_r <= 1'b0;
            out_count_r <= ACC_ZERO;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acc_r       <= acc_next_s;
            out_valid_r <= out_valid_next_s;
            out_count_r <= out_count_next_s;
            overrun_r   <= overrun_next_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_rate_meter
// Drives a 16-bit and a 4-bit pulse_rate_meter with identical stimulus and
// compares every cycle against a window-level reference model that counts
// events as unbounded integers and folds them (wrap or saturate) at the end.
// -----------------------------------------------------------------------------
module tb_pulse_rate_meter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [15:0] window_length;
    logic        pulses_in;
    logic        out_ready;

    logic        v0, o0, v1, o1;
    logic [15:0] c0;
    logic [3:0]  c1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pulse_rate_meter #(.WORD_WIDTH(16), .WINDOW_WIDTH(16)) u_dut_wide (
        .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
        .window_length(window_length), .pulses_in(pulses_in),
        .out_valid(v0), .out_ready(out_ready), .out_count(c0), .overrun(o0)
    );

    pulse_rate_meter #(.WORD_WIDTH(4), .WINDOW_WIDTH(16)) u_dut_narrow (
        .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
        .window_length(window_length), .pulses_in(pulses_in),
        .out_valid(v1), .out_ready(out_ready), .out_count(c1), .overrun(o1)
    );

    // Reference model, one slot per DUT.
    int     m_width [2] = '{16, 4};
    bit     m_active[2];
    int     m_left  [2];
    longint m_events[2];
    bit     m_valid [2];
    longint m_count [2];
    bit     m_over  [2];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint fold(input int idx, input longint ev);
        longint maxv;
        maxv = (longint'(1) << m_width[idx]) - 1;
`ifdef PULSE_RATE_METER_SATURATE_EN
        return (ev > maxv) ? maxv : ev;
`else
        return ev % (maxv + 1);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_left[i] = 0; m_events[i] = 0;
            m_valid[i] = 1'b0;  m_count[i] = 0; m_over[i] = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step(input int idx);
        bit     done;
        longint res;
        int     reload;
        done   = 1'b0;
        res    = 0;
        reload = (window_length == 16'd0) ? 1 : int'(window_length);
        if (!m_active[idx]) begin
            if (enable) begin
                m_active[idx] = 1'b1; m_left[idx] = reload; m_events[idx] = 0;
            end
        end else if (!enable) begin
            m_active[idx] = 1'b0;
        end else if (restart) begin
            m_left[idx] = reload; m_events[idx] = 0;
        end else begin
            m_events[idx] += longint'(pulses_in);
            if (m_left[idx] == 1) begin
                done = 1'b1; res = m_events[idx];
                m_left[idx] = reload; m_events[idx] = 0;
            end else begin
                m_left[idx]--;
            end
        end
        if (done && (!m_valid[idx] || out_ready)) begin
            m_valid[idx] = 1'b1; m_count[idx] = fold(idx, res);
        end else if (done) begin
            m_over[idx] = 1'b1;
        end else if (m_valid[idx] && out_ready) begin
            m_valid[idx] = 1'b0;
        end
        if (restart) m_over[idx] = 1'b0;
    endtask

    task automatic compare_all();
        check_value("valid_w16",   32'(v0), 32'(m_valid[0]));
        check_value("count_w16",   32'(c0), 32'(m_count[0]));
        check_value("overrun_w16", 32'(o0), 32'(m_over[0]));
        check_value("valid_w4",    32'(v1), 32'(m_valid[1]));
        check_value("count_w4",    32'(c1), 32'(m_count[1]));
        check_value("overrun_w4",  32'(o1), 32'(m_over[1]));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int nres;
        int guard;
        logic [31:0] exp_sat;

        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; pulses_in = 1'b0;
        out_ready = 1'b1; window_length = 16'd8;
        model_reset();
        #1;
        compare_all();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Constant pulses, window 8: first result 9 edges after enable rises.
        enable = 1'b1; pulses_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!v0 && n < 30);
        check_value("first_result_latency", 32'(n), 32'd9);
        check_value("first_count", 32'(c0), 32'd8);
        nres = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (v0) nres++;
        end
        check_value("valid_pulse_count", 32'(nres), 32'd3);

        // Window 4, single pulse on each final cycle only.
        enable = 1'b0; pulses_in = 1'b0; window_length = 16'd4;
        tick();
        enable = 1'b1;
        tick();
        nres = 0;
        for (int i = 0; i < 16; i++) begin
            pulses_in = (m_active[0] && m_left[0] == 1);
            tick();
            if (v0) begin
                nres++;
                check_value("final_only_count", 32'(c0), 32'd1);
            end
        end
        check_value("final_only_results", 32'(nres), 32'd4);

        // Stalled consumer across two completions, then restart clears overrun.
        restart = 1'b1; pulses_in = 1'b0;
        tick();
        restart = 1'b0; out_ready = 1'b0; pulses_in = 1'b1;
        repeat (8) tick();
        check_value("stall_overrun", 32'(o0), 32'd1);
        check_value("stall_held_count", 32'(c0), 32'd4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_value("restart_clears_overrun", 32'(o0), 32'd0);
        check_value("restart_keeps_count", 32'(c0), 32'd4);
        check_value("restart_keeps_valid", 32'(v0), 32'd1);

        // Restart on a final cycle with a pulse: no result, fresh count after.
        out_ready = 1'b1;
        repeat (2) tick();
        guard = 0;
        while (!(m_active[0] && m_left[0] == 1) && guard < 20) begin
            tick();
            guard++;
        end
        check_value("final_cycle_reached", 32'(guard < 20), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_value("restart_no_valid", 32'(v0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulses_in = (i >= 2);
            tick();
        end
        check_value("post_restart_valid", 32'(v0), 32'd1);
        check_value("post_restart_count", 32'(c0), 32'd2);

        // Narrow counter over a 20-cycle window: wrap or saturate.
        enable = 1'b0;
        tick();
        window_length = 16'd20; pulses_in = 1'b1; enable = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!v1 && guard < 40);
`ifdef PULSE_RATE_METER_SATURATE_EN
        exp_sat = 32'd15;
`else
        exp_sat = 32'd4;
`endif
        check_value("narrow_fold_count", 32'(c1), exp_sat);
        check_value("wide_full_count", 32'(c0), 32'd20);

        // Randomized operation.
        for (int i = 0; i < 2500; i++) begin
            enable    = ($urandom_range(0, 19) != 0);
            restart   = ($urandom_range(0, 29) == 0);
            pulses_in = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) window_length = 16'($urandom_range(0, 24));
            tick();
        end

        // Asynchronous reset while a result is pending.
        enable = 1'b1; restart = 1'b0; out_ready = 1'b0; pulses_in = 1'b1;
        window_length = 16'd3;
        guard = 0;
        while (!v0 && guard < 40) begin
            tick();
            guard++;
        end
        check_value("pending_before_reset", 32'(v0), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_value("async_reset_valid", 32'(v0), 32'd0);
        check_value("async_reset_count", 32'(c0), 32'd0);
        check_value("async_reset_overrun", 32'(o0), 32'd0);
        compare_all();
        tick();
        reset_n = 1'b1;
        enable = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
